// File: rtl/x_multdiv_pkg.sv
// Shared types and constants for the iterative Booth multiply / restoring divide unit.
package x_multdiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    localparam logic [ITER-1:0] INT_MIN = {1'b1, {(ITER-1){1'b0}}};
    localparam logic [ITER-1:0] NEG_ONE = '1;

endpackage

// File: rtl/x_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module x_div_step
    import x_multdiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // rem < divisor holds between steps, so the shifted value needs one extra bit.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});

    always_comb begin
        rem_next = WIDTH'(shifted);
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_next = WIDTH'(shifted - {1'b0, divisor});
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/x_multdiv.sv
// Iterative signed multiply/divide: radix-2 Booth multiply, restoring divide, one bit per cycle.
// Define X_MULTDIV_DIV_EN to build the divide path; otherwise a divide start reports an illegal op.
module x_multdiv
    import x_multdiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    op_t              start_op;
    logic             start;
    logic             last_iter;
    logic [CNT_W-1:0] count;

    // Booth working set; acc carries a guard bit so acc -/+ INT_MIN cannot overflow.
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     acc_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               q_1_shift;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_op  = ctrl_MULT ? OP_MUL : OP_DIV;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        unique case ({q[0], q_1})
            2'b01:   acc_sum = acc + {mcand[WIDTH-1], mcand};
            2'b10:   acc_sum = acc - {mcand[WIDTH-1], mcand};
            default: acc_sum = acc;
        endcase
    end

    assign {acc_shift, q_shift, q_1_shift} = {acc_sum[WIDTH], acc_sum, q};
    assign product = {acc_shift[WIDTH-1:0], q_shift};
    assign mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

`ifdef X_MULTDIV_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_quo;
    logic             div_ovf;

    assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    x_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (start) begin
            if (start_op == OP_MUL) begin
                state_next = MUL;
            end else begin
`ifdef X_MULTDIV_DIV_EN
                state_next = (data_operandB == '0) ? DONE : DIV;
`else
                state_next = DONE;
`endif
            end
        end else begin
            unique case (state)
                MUL:     if (last_iter) state_next = DONE;
`ifdef X_MULTDIV_DIV_EN
                DIV:     if (last_iter) state_next = DONE;
`endif
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        data_resultRDY = (state == DONE);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count          <= '0;
            acc            <= '0;
            mcand          <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef X_MULTDIV_DIV_EN
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            neg_quo        <= 1'b0;
            div_ovf        <= 1'b0;
`endif
        end else if (start) begin
            count <= '0;
            if (start_op == OP_MUL) begin
                acc   <= '0;
                mcand <= data_operandA;
                q     <= data_operandB;
                q_1   <= 1'b0;
            end else begin
`ifdef X_MULTDIV_DIV_EN
                rem     <= '0;
                quo     <= a_mag;
                divisor <= b_mag;
                neg_quo <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_ovf <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
                if (data_operandB == '0) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end
`else
                data_result    <= '0;
                data_exception <= 1'b1;
`endif
            end
        end else begin
            case (state)
                MUL: begin
                    acc   <= acc_shift;
                    q     <= q_shift;
                    q_1   <= q_1_shift;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        data_result    <= product[WIDTH-1:0];
                        data_exception <= mul_ovf;
                    end
                end
`ifdef X_MULTDIV_DIV_EN
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        if (div_ovf) begin
                            data_result <= INT_MIN;
                        end else begin
                            data_result <= neg_quo ? (~quo_next + 1'b1) : quo_next;
                        end
                        data_exception <= div_ovf;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
